// File: rtl/vdp_pkg.sv
// ============================================================================
// Module      : vdp_pkg
// Description : Shared types and constants for the draw-domain tile fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vdp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    FETCH = 2'd2
  } fetch_state_t;

  localparam int TILE_PX = 4;
  // Each fetched word is pixel-doubled, so the line buffer advances 8 px per fetch
  localparam int LB_STEP = 2 * TILE_PX;
  localparam int LB_XW   = 12;

endpackage

`default_nettype wire

// File: rtl/tile_fetch_sequencer.sv
// ============================================================================
// Module      : tile_fetch_sequencer
// Description : Sequences tile-BRAM fetches for one display line per line pulse;
//               owns the frame counter, frame-synchronous scroll and overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_fetch_sequencer
  import vdp_pkg::*;
#(
  parameter int CORDW          = 11,
  parameter int WORDS_PER_LINE = 80,
  parameter int LINES          = 480
) (
  input  logic             clk_draw,
  input  logic             rst_draw,
  input  logic             line,
  input  logic             frame,
  input  logic [CORDW-1:0] sy,
  input  logic             scroll_we,
  input  logic [11:0]      scroll_x,
  output logic             fetch_valid,
  output logic             first,
  output logic [4:0]       tile_y,
  output logic [4:0]       tile_x,
  output logic [2:0]       tile_row,
  output logic             tile_col,
  output logic [11:0]      lb_x,
  output logic             bufsel,
  output logic             busy,
  output logic             overrun,
  output logic [11:0]      frame_counter
);

  localparam int KW = $clog2(WORDS_PER_LINE);

  fetch_state_t     state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [LB_XW-1:0] scroll_pend_q, scroll_pend_d;
  logic [LB_XW-1:0] scroll_cur_q, scroll_cur_d;
  logic [11:0]      frame_counter_q, frame_counter_d;
  logic             overrun_q, overrun_d;
  logic             bufsel_q, bufsel_d;
  logic             busy_q, busy_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             first_q, first_d;
  logic [4:0]       tile_y_q, tile_y_d;
  logic [4:0]       tile_x_q, tile_x_d;
  logic [2:0]       tile_row_q, tile_row_d;
  logic             tile_col_q, tile_col_d;
  logic [LB_XW-1:0] lb_x_q, lb_x_d;

  logic [8:0]       t_next;
  logic             emit;
  logic             overrun_set;
  logic [KW-1:0]    fk;

  always_comb begin
    t_next          = (sy >= CORDW'(LINES - 1)) ? 9'd0 : 9'(sy + CORDW'(1));
    state_d         = state_q;
    k_d             = k_q;
    bufsel_d        = bufsel_q;
    tile_y_d        = tile_y_q;
    tile_row_d      = tile_row_q;
    tile_x_d        = tile_x_q;
    tile_col_d      = tile_col_q;
    lb_x_d          = lb_x_q;
    fetch_valid_d   = 1'b0;
    first_d         = 1'b0;
    emit            = 1'b0;
    overrun_set     = 1'b0;
    fk              = k_q;

    case (state_q)
      IDLE: begin
        if (line) state_d = PRIME;
      end
      PRIME: begin
        if (line) begin
          overrun_set = 1'b1;
        end else begin
          // Row fields and buffer select are fixed for the whole line
          state_d    = FETCH;
          tile_y_d   = t_next[8:4];
          tile_row_d = t_next[3:1];
          bufsel_d   = t_next[0];
          fk         = '0;
          k_d        = KW'(1);
          emit       = 1'b1;
        end
      end
      FETCH: begin
        if (line) begin
          overrun_set = 1'b1;
          state_d     = PRIME;
        end else if (k_q == KW'(WORDS_PER_LINE)) begin
          state_d = IDLE;
        end else begin
          k_d  = k_q + KW'(1);
          emit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      fetch_valid_d = 1'b1;
      first_d       = (fk == '0);
      tile_x_d      = fk[5:1];
      tile_col_d    = fk[0];
      lb_x_d        = scroll_cur_q + LB_XW'(fk) * LB_XW'(LB_STEP);
    end

    busy_d          = (state_d != IDLE);
    overrun_d       = overrun_set ? 1'b1 : (frame ? 1'b0 : overrun_q);
    // A write coinciding with frame reaches scroll_cur directly through pend_d
    scroll_pend_d   = scroll_we ? scroll_x : scroll_pend_q;
    scroll_cur_d    = frame ? scroll_pend_d : scroll_cur_q;
    frame_counter_d = frame_counter_q + {11'd0, frame};
  end

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      state_q         <= IDLE;
      k_q             <= '0;
      scroll_pend_q   <= '0;
      scroll_cur_q    <= '0;
      frame_counter_q <= '0;
      overrun_q       <= 1'b0;
      bufsel_q        <= 1'b0;
      busy_q          <= 1'b0;
      fetch_valid_q   <= 1'b0;
      first_q         <= 1'b0;
      tile_y_q        <= '0;
      tile_x_q        <= '0;
      tile_row_q      <= '0;
      tile_col_q      <= 1'b0;
      lb_x_q          <= '0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      scroll_pend_q   <= scroll_pend_d;
      scroll_cur_q    <= scroll_cur_d;
      frame_counter_q <= frame_counter_d;
      overrun_q       <= overrun_d;
      bufsel_q        <= bufsel_d;
      busy_q          <= busy_d;
      fetch_valid_q   <= fetch_valid_d;
      first_q         <= first_d;
      tile_y_q        <= tile_y_d;
      tile_x_q        <= tile_x_d;
      tile_row_q      <= tile_row_d;
      tile_col_q      <= tile_col_d;
      lb_x_q          <= lb_x_d;
    end
  end

  assign fetch_valid   = fetch_valid_q;
  assign first         = first_q;
  assign tile_y        = tile_y_q;
  assign tile_x        = tile_x_q;
  assign tile_row      = tile_row_q;
  assign tile_col      = tile_col_q;
  assign lb_x          = lb_x_q;
  assign bufsel        = bufsel_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;
  assign frame_counter = frame_counter_q;

endmodule

`default_nettype wire

// File: tb/tb_tile_fetch_sequencer.sv
// ============================================================================
// Module      : tb_tile_fetch_sequencer
// Description : Directed bench for tile_fetch_sequencer with a fetch scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_fetch_sequencer;

  logic        clk_draw = 1'b0;
  logic        rst_draw;
  logic        line;
  logic        frame;
  logic [10:0] sy;
  logic        scroll_we;
  logic [11:0] scroll_x;
  logic        fetch_valid;
  logic        first;
  logic [4:0]  tile_y;
  logic [4:0]  tile_x;
  logic [2:0]  tile_row;
  logic        tile_col;
  logic [11:0] lb_x;
  logic        bufsel;
  logic        busy;
  logic        overrun;
  logic [11:0] frame_counter;

  typedef struct packed {
    logic [31:0] cyc;
    logic        first;
    logic        bufsel;
    logic [4:0]  ty;
    logic [4:0]  tx;
    logic [2:0]  tr;
    logic        tc;
    logic [11:0] lbx;
  } fetch_t;

  fetch_t exp_q[$];
  fetch_t mon_got;
  fetch_t mon_exp;
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     fc_exp = 0;

  tile_fetch_sequencer #(
    .CORDW(11), .WORDS_PER_LINE(80), .LINES(480)
  ) dut (
    .clk_draw(clk_draw), .rst_draw(rst_draw), .line(line), .frame(frame),
    .sy(sy), .scroll_we(scroll_we), .scroll_x(scroll_x),
    .fetch_valid(fetch_valid), .first(first), .tile_y(tile_y), .tile_x(tile_x),
    .tile_row(tile_row), .tile_col(tile_col), .lb_x(lb_x), .bufsel(bufsel),
    .busy(busy), .overrun(overrun), .frame_counter(frame_counter)
  );

  always #5 clk_draw = ~clk_draw;
  always @(posedge clk_draw) cyc <= cyc + 1;

  // Scoreboard consumer: every valid fetch must match the next expected record
  always @(negedge clk_draw) begin
    if (!rst_draw && fetch_valid) begin
      mon_got = '{cyc: cyc, first: first, bufsel: bufsel, ty: tile_y, tx: tile_x,
                  tr: tile_row, tc: tile_col, lbx: lb_x};
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL fetch_unexpected: observed fetch %h at cycle %0d, expected none", mon_got, cyc);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        checks++;
        assert (mon_got === mon_exp) else begin
          errors++;
          $error("FAIL fetch: observed %h expected %h", mon_got, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_draw);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic push_line(input int n0, input int sy_v, input int base, input int count);
    int t;
    fetch_t e;
    t = (sy_v >= 479) ? 0 : sy_v + 1;
    for (int k = 0; k < count; k++) begin
      e.cyc    = 32'(n0 + 2 + k);
      e.first  = (k == 0);
      e.bufsel = 1'(t & 1);
      e.ty     = 5'((t >> 4) & 31);
      e.tr     = 3'((t >> 1) & 7);
      e.tx     = 5'((k >> 1) & 31);
      e.tc     = 1'(k & 1);
      e.lbx    = 12'((base + 8 * k) % 4096);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_line(input int sy_v, input int base, input int count, output int n0);
    line = 1'b1;
    sy   = 11'(sy_v);
    n0   = cyc;
    push_line(n0, sy_v, base, count);
    step();
    line = 1'b0;
  endtask

  task automatic run_line(input int sy_v, input int base);
    int n0;
    start_line(sy_v, base, 80, n0);
    goto_cyc(n0 + 83);
    #2;
    chk("line_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    step();
    frame = 1'b0;
    fc_exp = (fc_exp + 1) % 4096;
    #2;
    chk("frame_counter", 32'(frame_counter), 32'(fc_exp));
  endtask

  task automatic write_scroll(input int v);
    scroll_we = 1'b1;
    scroll_x  = 12'(v);
    step();
    scroll_we = 1'b0;
  endtask

  initial begin
    int n0;
    int n1;
    rst_draw  = 1'b1;
    line      = 1'b0;
    frame     = 1'b0;
    sy        = '0;
    scroll_we = 1'b0;
    scroll_x  = '0;
    repeat (3) step();
    rst_draw = 1'b0;
    #2;
    chk("rst_fetch_valid", 32'(fetch_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_frame_counter", 32'(frame_counter), 0);
    chk("rst_lb_x", 32'(lb_x), 0);
    chk("rst_bufsel", 32'(bufsel), 0);
    chk("rst_first", 32'(first), 0);
    chk("rst_tile_y", 32'(tile_y), 0);

    // First line with latency and busy-window checks
    step();
    start_line(9, 0, 80, n0);
    #2;
    chk("prime_busy", 32'(busy), 1);
    chk("prime_no_fetch", 32'(fetch_valid), 0);
    goto_cyc(n0 + 81);
    #2;
    chk("last_fetch_busy", 32'(busy), 1);
    goto_cyc(n0 + 82);
    #2;
    chk("busy_dropped", 32'(busy), 0);
    chk("line_drained", 32'(exp_q.size()), 0);

    // Target-line wrap, tile row boundaries and odd buffer select
    run_line(479, 0);
    run_line(31, 0);
    run_line(20, 0);

    // Scroll write is invisible until a frame pulse
    write_scroll(4090);
    run_line(100, 0);
    pulse_frame();
    run_line(8, 4090);

    // Overrun: second line 40 cycles into the first
    start_line(50, 4090, 39, n0);
    goto_cyc(n0 + 40);
    #2;
    chk("overrun_before", 32'(overrun), 0);
    start_line(60, 4090, 80, n1);
    #2;
    chk("overrun_set", 32'(overrun), 1);
    chk("overrun_busy", 32'(busy), 1);
    goto_cyc(n1 + 83);
    #2;
    chk("line_drained", 32'(exp_q.size()), 0);
    pulse_frame();
    chk("overrun_cleared", 32'(overrun), 0);

    // Overrun coinciding with frame: set wins over clear
    start_line(70, 4090, 9, n0);
    goto_cyc(n0 + 10);
    frame = 1'b1;
    start_line(71, 4090, 80, n1);
    frame = 1'b0;
    fc_exp = (fc_exp + 1) % 4096;
    #2;
    chk("overrun_set_wins", 32'(overrun), 1);
    chk("frame_counter", 32'(frame_counter), 32'(fc_exp));
    goto_cyc(n1 + 83);
    #2;
    chk("line_drained", 32'(exp_q.size()), 0);
    pulse_frame();
    chk("overrun_cleared2", 32'(overrun), 0);

    // Frame and line together after a scroll write
    write_scroll(16);
    frame = 1'b1;
    start_line(100, 16, 80, n0);
    frame = 1'b0;
    fc_exp = (fc_exp + 1) % 4096;
    #2;
    chk("frame_counter", 32'(frame_counter), 32'(fc_exp));
    goto_cyc(n0 + 83);
    #2;
    chk("line_drained", 32'(exp_q.size()), 0);

    // Scroll write and frame in the same cycle
    scroll_we = 1'b1;
    scroll_x  = 12'd100;
    frame     = 1'b1;
    step();
    scroll_we = 1'b0;
    frame     = 1'b0;
    fc_exp = (fc_exp + 1) % 4096;
    run_line(5, 100);

    // Frame counter wrap
    frame = 1'b1;
    repeat (4095 - fc_exp) step();
    frame = 1'b0;
    fc_exp = 4095;
    #2;
    chk("frame_counter_max", 32'(frame_counter), 4095);
    pulse_frame();
    chk("frame_counter_wrap", 32'(frame_counter), 0);

    // Asynchronous reset in the middle of a line
    step();
    start_line(150, 100, 18, n0);
    goto_cyc(n0 + 20);
    #2;
    rst_draw = 1'b1;
    #1;
    chk("arst_fetch_valid", 32'(fetch_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_bufsel", 32'(bufsel), 0);
    chk("arst_lb_x", 32'(lb_x), 0);
    chk("arst_tile_x", 32'(tile_x), 0);
    chk("arst_tile_row", 32'(tile_row), 0);
    chk("arst_frame_counter", 32'(frame_counter), 0);
    chk("arst_drained", 32'(exp_q.size()), 0);
    repeat (2) step();
    rst_draw = 1'b0;
    fc_exp = 0;
    step();
    run_line(200, 0);
    chk("post_rst_overrun", 32'(overrun), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
